console_uart_tx: RTL and testbench

Wishbone-slave transmit console: the successor to the simulation-only byte console. CPU writes are buffered in a parametrised FIFO and serialised onto a real 8N1 UART line with a programmable baud divisor. The block also provides:
- a status register (level, full, empty, busy, overflow);
- a selectable full-FIFO policy (stall the bus or drop and flag);
- a TX-done interrupt.

It sits on the peripheral Wishbone bus beside RAM and timer.

---
 rtl/console_uart_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_console_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/console_uart_tx.sv
// console_uart_tx: Wishbone transmit console.
// Buffers CPU bytes in a FIFO and sends them as 8N1 UART frames.
module console_uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 867
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [LW-1:0]        level_q;
  logic                 tx_en_q, block_q, irq_en_q, ovf_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 ack_q, irq_q;
  logic [31:0]          rdata_q, rd_mux, lvl32;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, dlat_q, dlat_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;
  logic                 tx_q, tx_d;

  logic empty, full, wr_txd, stall, accept, wr;
  logic push, drop, flush, pop, tick, busy;
  logic unused_bits;

  assign empty  = (level_q == '0);
  assign full   = (level_q == LW'(FIFO_DEPTH));
  assign wr_txd = i_wb_stb && i_wb_we && (i_wb_addr == 2'd0);
  assign stall  = wr_txd && full && block_q;
  assign accept = i_wb_stb && !stall;
  assign wr     = accept && i_wb_we;
  // Full is judged before any same-cycle pop: a push on full never merges.
  assign push   = wr && (i_wb_addr == 2'd0) && !full;
  assign drop   = wr && (i_wb_addr == 2'd0) && full;
  assign flush  = wr && (i_wb_addr == 2'd2) && i_wb_data[1];
  assign tick   = (cnt_q == dlat_q);
  assign busy   = (state_q != S_IDLE);
  assign lvl32  = 32'(level_q);
  assign unused_bits = ^{i_wb_data, lvl32};

  // Read-data mux for the register map.
  always_comb begin
    rd_mux = '0;
    unique case (i_wb_addr)
      2'd0: rd_mux = '0;
      2'd1: rd_mux = {8'h00, lvl32[7:0], 12'h000,
                      ovf_q, busy, full, empty};
      2'd2: rd_mux = {28'h0, irq_en_q, block_q, 1'b0, tx_en_q};
      2'd3: rd_mux = 32'(div_q);
    endcase
  end

  // Bus response: registered ack and read data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= (accept && !i_wb_we) ? rd_mux : '0;
    end
  end

  // Control, divisor and sticky overflow registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_en_q  <= 1'b1;
      block_q  <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= DIV_WIDTH'(DIV_RESET);
      ovf_q    <= 1'b0;
    end else begin
      if (wr && i_wb_addr == 2'd2) begin
        tx_en_q  <= i_wb_data[0];
        block_q  <= i_wb_data[2];
        irq_en_q <= i_wb_data[3];
      end
      if (wr && i_wb_addr == 2'd3)
        div_q <= i_wb_data[DIV_WIDTH-1:0];
      if (drop)
        ovf_q <= 1'b1;
      else if (wr && i_wb_addr == 2'd1 && i_wb_data[3])
        ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (push)
      mem_q[wptr_q] <= i_wb_data[7:0];
  end

  // FIFO pointers and level; flush wins over push and pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Serialiser next state; divisor is captured at the pop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en_q && !empty && !flush) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = '0;
          dlat_d  = div_q;
          sh_d    = mem_q[rptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = sh_q[0];
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            sh_d = sh_q >> 1;
            tx_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
    endcase
  end

  // Serialiser state; reset drives the line high at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dlat_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  // TX-done interrupt: enabled, drained and idle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      irq_q <= 1'b0;
    else
      irq_q <= irq_en_q && empty && (state_q == S_IDLE);
  end

  assign o_wb_data  = rdata_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_stall = stall;
  assign o_tx       = tx_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: directed and randomized checks
// of console_uart_tx against a frame-level line model.
module tb_console_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, stall, tx, irq;

  int ncmp = 0;
  int nfail = 0;

  console_uart_tx dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_addr  (addr),
    .i_wb_data  (wdata),
    .o_wb_data  (rdata),
    .o_wb_ack   (ack),
    .o_wb_stall (stall),
    .o_tx       (tx),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles after the start bit begins.
  function automatic logic exp_tx(input logic [7:0] b, input int d,
                                  input int k);
    int idx;
    idx = k / (d + 1);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // One bus transaction; called and returns on a falling edge.
  task automatic wb(input logic [1:0] a, input logic w,
                    input logic [31:0] d, output logic [31:0] r);
    stb = 1'b1; we = w; addr = a; wdata = d;
    chk("bus_not_stalled", 32'(stall), 32'd0);
    @(posedge clk);
    #1 stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("bus_ack", 32'(ack), 32'd1);
    r = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb(a, 1'b1, d, r);
    chk("write_rdata_zero", r, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    wb(a, 1'b0, 32'd0, r);
  endtask

  // Decode one frame by sampling mid-bit.
  task automatic rx_byte(input int d, output logic [7:0] b);
    int n;
    n = 0;
    b = '0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_start_seen", 32'(tx), 32'd0);
    repeat (d / 2) @(negedge clk);
    chk("rx_start_mid", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (d + 1) @(negedge clk);
      b[i] = tx;
    end
    repeat (d + 1) @(negedge clk);
    chk("rx_stop_mid", 32'(tx), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b, b0;
    logic [7:0]  q[$];
    int          d, n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, r); chk("rst_status", r, 32'h0000_0001);
    rd(2'd3, r); chk("rst_div", r, 32'd867);
    rd(2'd2, r); chk("rst_ctrl", r, 32'h1);
    rd(2'd0, r); chk("txdata_reads_zero", r, 32'd0);

    // 0x55 at DIV=3, cycle-exact line check
    wr(2'd3, 32'd3);
    rd(2'd3, r); chk("div_rw", r, 32'd3);
    wr(2'd0, 32'h55);
    chk("tx_high_before_start", 32'(tx), 32'd1);
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      chk("tx_0x55", 32'(tx), 32'(exp_tx(8'h55, 3, k)));
    end
    rd(2'd1, r); chk("status_after_0x55", r, 32'h1);

    // Random bytes at random divisors
    repeat (4) begin
      d = int'($urandom_range(0, 5));
      b = 8'($urandom);
      wr(2'd3, 32'(d));
      wr(2'd0, 32'(b));
      for (int k = 0; k < 10 * (d + 1) + 2; k++) begin
        @(negedge clk);
        chk("tx_rand", 32'(tx), 32'(exp_tx(b, d, k)));
      end
    end

    // Busy during a frame, idle after
    wr(2'd3, 32'd7);
    wr(2'd0, 32'($urandom_range(0, 255)));
    @(negedge clk);
    rd(2'd1, r); chk("status_busy", r, 32'h0000_0005);
    repeat (90) @(negedge clk);
    rd(2'd1, r); chk("status_idle", r, 32'h1);

    // Drop-mode overfill, then drain and check order
    wr(2'd2, 32'h0);
    wr(2'd3, 32'd3);
    q.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      wr(2'd0, 32'(b));
      if (i < 16) q.push_back(b);
    end
    rd(2'd1, r); chk("status_full_ovf", r, 32'h0010_000A);
    wr(2'd1, 32'h8);
    rd(2'd1, r); chk("status_ovf_cleared", r, 32'h0010_0002);
    wr(2'd2, 32'h1);
    for (int i = 0; i < 16; i++) begin
      rx_byte(3, b);
      chk("rx_fifo_order", 32'(b), 32'(q.pop_front()));
    end
    repeat (20) @(negedge clk);
    rd(2'd1, r); chk("status_drained", r, 32'h1);

    // Block-mode overfill: 17th write stalls until a pop
    wr(2'd2, 32'h4);
    for (int i = 0; i < 16; i++) wr(2'd0, 32'($urandom_range(0, 255)));
    rd(2'd1, r); chk("status_block_full", r, 32'h0010_0002);
    stb = 1'b1; we = 1'b1; addr = 2'd0;
    wdata = 32'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_on_full", 32'(stall), 32'd1);
      chk("no_ack_while_stalled", 32'(ack), 32'd0);
    end
    force dut.tx_en_q = 1'b1;
    n = 0;
    while (stall && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_release_cycles", 32'(n), 32'd1);
    @(posedge clk);
    #1 stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("ack_after_stall", 32'(ack), 32'd1);
    release dut.tx_en_q;
    rd(2'd1, r); chk("status_refilled", r, 32'h0010_0006);
    wr(2'd2, 32'h2);
    rd(2'd1, r); chk("status_flushed_busy", r, 32'h0000_0005);
    repeat (50) @(negedge clk);
    rd(2'd1, r); chk("status_after_flush", r, 32'h1);

    // Mid-frame DIV change and tx_en clear
    wr(2'd2, 32'h0);
    b0 = 8'($urandom);
    wr(2'd0, 32'(b0));
    wr(2'd0, 32'($urandom_range(0, 255)));
    wr(2'd3, 32'd3);
    wr(2'd2, 32'h1);
    wr(2'd3, 32'd7);
    wr(2'd2, 32'h0);
    chk("tx_midframe", 32'(tx), 32'(exp_tx(b0, 3, 1)));
    for (int k = 2; k < 46; k++) begin
      @(negedge clk);
      chk("tx_midframe", 32'(tx), 32'(exp_tx(b0, 3, k)));
    end
    rd(2'd1, r); chk("status_one_held", r, 32'h0001_0000);
    wr(2'd2, 32'h2);
    rd(2'd1, r); chk("status_cleared", r, 32'h1);

    // TX-done interrupt over two frames
    wr(2'd3, 32'd3);
    wr(2'd2, 32'h9);
    @(negedge clk);
    chk("irq_idle_empty", 32'(irq), 32'd1);
    wr(2'd0, 32'($urandom_range(0, 255)));
    wr(2'd0, 32'($urandom_range(0, 255)));
    chk("irq_low_after_push", 32'(irq), 32'd0);
    n = 0;
    while (irq !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("irq_rise_two_frames", 32'(n), 32'(2 * 10 * (3 + 1) + 2));

    // Flush during the first frame
    wr(2'd0, 32'($urandom_range(0, 255)));
    wr(2'd0, 32'($urandom_range(0, 255)));
    wr(2'd2, 32'hB);
    rd(2'd1, r); chk("flush_level_zero", r, 32'h0000_0005);
    n = 0;
    while (irq !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("irq_rise_after_flush", 32'(n), 32'(10 * (3 + 1) + 2 - 3));
    rd(2'd1, r); chk("status_no_second_frame", r, 32'h1);

    // Reset in the middle of a frame
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h00);
    repeat (10) @(negedge clk);
    chk("tx_low_in_frame", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("tx_high_on_reset", 32'(tx), 32'd1);
    chk("irq_low_on_reset", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, r); chk("status_post_reset", r, 32'h1);
    rd(2'd2, r); chk("ctrl_post_reset", r, 32'h1);
    rd(2'd3, r); chk("div_post_reset", r, 32'd867);
    repeat (5) @(negedge clk);
    chk("tx_idle_post_reset", 32'(tx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
